// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Issues load/store requests over a req/ready/rvalid handshake, lines up and
// extends load data, builds store byte enables, and holds upstream while an
// access is in flight.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | accept EX/MEM; non-memop/misaligned pass straight to MEM/WB
// REQ    | dmem_req high, request fields frozen until dmem_ready
// WAIT   | load accepted, waiting for dmem_rvalid
// DONE   | access finished, MEM/WB loads the instruction with its result
module mem_stage #(
   parameter int WIDTH    = 32,
   parameter int ADDR_LEN = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_i,
   input  logic [ADDR_LEN-1:0] pc_i,
   input  logic [WIDTH-1:0]    alu_out_i,
   input  logic [WIDTH-1:0]    rs2_data_i,
   input  logic [4:0]          rd_addr_i,
   input  logic                rf_w_en_i,
   input  logic [1:0]          wbsel_i,
   input  logic                mem_w_en_i,
   input  logic [2:0]          funct3_i,
   output logic                stall_o,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [ADDR_LEN-1:0] dmem_addr,
   output logic [WIDTH-1:0]    dmem_wdata,
   output logic [3:0]          dmem_be,
   input  logic                dmem_ready,
   input  logic                dmem_rvalid,
   input  logic [WIDTH-1:0]    dmem_rdata,
   output logic                valid_o,
   output logic [ADDR_LEN-1:0] pc_o,
   output logic [WIDTH-1:0]    alu_out_o,
   output logic [4:0]          rd_addr_o,
   output logic                rf_w_en_o,
   output logic [1:0]          wbsel_o,
   output logic [WIDTH-1:0]    load_data_o,
   output logic                misalign_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t              r_state;
   logic                r_is_store;
   logic [2:0]          r_f3;
   logic [1:0]          r_off;
   logic [WIDTH-1:0]    r_ld_cap;
   logic                r_dmem_we;
   logic [ADDR_LEN-1:0] r_dmem_addr;
   logic [WIDTH-1:0]    r_dmem_wdata;
   logic [3:0]          r_dmem_be;
   logic                r_valid;
   logic [ADDR_LEN-1:0] r_pc;
   logic [WIDTH-1:0]    r_alu;
   logic [4:0]          r_rd;
   logic                r_rf_w_en;
   logic [1:0]          r_wbsel;
   logic [WIDTH-1:0]    r_load_data;
   logic                r_misalign;

   logic                w_load;
   logic                w_store;
   logic                w_memop;
   logic                w_misalign;
   logic                w_accept;
   logic [1:0]          w_off;
   logic [3:0]          w_be;
   logic [WIDTH-1:0]    w_wdata;

   // Picks the addressed byte/halfword out of the returned word and extends it.
   function automatic logic [WIDTH-1:0] align_load(input logic [WIDTH-1:0] word,
                                                   input logic [1:0]       off,
                                                   input logic [2:0]       f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  align_load = {{(WIDTH-8){b[7]}}, b};
         3'b100:  align_load = {{(WIDTH-8){1'b0}}, b};
         3'b001:  align_load = {{(WIDTH-16){h[15]}}, h};
         3'b101:  align_load = {{(WIDTH-16){1'b0}}, h};
         default: align_load = word;
      endcase
   endfunction

   // Classify the EX/MEM instruction and flag misaligned memops.
   always_comb begin
      w_load     = valid_i & (wbsel_i == 2'b01) & rf_w_en_i;
      w_store    = valid_i & mem_w_en_i;
      w_memop    = w_load | w_store;
      w_off      = alu_out_i[1:0];
      w_misalign = 1'b0;
      case (funct3_i)
         3'b000, 3'b100: w_misalign = 1'b0;
         3'b001, 3'b101: w_misalign = w_off[0];
         default:        w_misalign = |w_off;
      endcase
      w_misalign = w_misalign & w_memop;
      w_accept   = w_memop & ~w_misalign;
   end

   // Store lane replication and byte enables; unused size codes act as word.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = rs2_data_i;
      case (funct3_i)
         3'b000: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{rs2_data_i[7:0]}};
         end
         3'b001: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{rs2_data_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = rs2_data_i;
         end
      endcase
   end

   // Access sequencer plus the MEM/WB register it controls.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_is_store   <= 1'b0;
         r_f3         <= '0;
         r_off        <= '0;
         r_ld_cap     <= '0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_dmem_be    <= '0;
         r_valid      <= 1'b0;
         r_pc         <= '0;
         r_alu        <= '0;
         r_rd         <= '0;
         r_rf_w_en    <= 1'b0;
         r_wbsel      <= '0;
         r_load_data  <= '0;
         r_misalign   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state      <= S_REQ;
                  r_is_store   <= w_store;
                  r_f3         <= funct3_i;
                  r_off        <= w_off;
                  r_ld_cap     <= '0;
                  r_dmem_we    <= w_store;
                  r_dmem_addr  <= {alu_out_i[ADDR_LEN-1:2], 2'b00};
                  r_dmem_wdata <= w_wdata;
                  r_dmem_be    <= w_be;
                  r_valid      <= 1'b0;
                  r_rf_w_en    <= 1'b0;
                  r_load_data  <= '0;
                  r_misalign   <= 1'b0;
               end else begin
                  r_valid     <= valid_i;
                  r_pc        <= pc_i;
                  r_alu       <= alu_out_i;
                  r_rd        <= rd_addr_i;
                  r_rf_w_en   <= rf_w_en_i & ~w_misalign;
                  r_wbsel     <= wbsel_i;
                  r_load_data <= '0;
                  r_misalign  <= w_misalign;
               end
            end
            S_REQ: begin
               if (dmem_ready) begin
                  r_state <= r_is_store ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (dmem_rvalid) begin
                  r_ld_cap <= align_load(dmem_rdata, r_off, r_f3);
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_valid     <= 1'b1;
               r_pc        <= pc_i;
               r_alu       <= alu_out_i;
               r_rd        <= rd_addr_i;
               r_rf_w_en   <= rf_w_en_i;
               r_wbsel     <= wbsel_i;
               r_load_data <= r_ld_cap;
               r_misalign  <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stall must rise in the same cycle an aligned memop shows up in IDLE.
   always_comb begin
      stall_o  = ~reset & (((r_state == S_IDLE) & w_accept) |
                           (r_state == S_REQ) | (r_state == S_WAIT));
      dmem_req = (r_state == S_REQ);
   end

   assign dmem_we     = r_dmem_we;
   assign dmem_addr   = r_dmem_addr;
   assign dmem_wdata  = r_dmem_wdata;
   assign dmem_be     = r_dmem_be;
   assign valid_o     = r_valid;
   assign pc_o        = r_pc;
   assign alu_out_o   = r_alu;
   assign rd_addr_o   = r_rd;
   assign rf_w_en_o   = r_rf_w_en;
   assign wbsel_o     = r_wbsel;
   assign load_data_o = r_load_data;
   assign misalign_o  = r_misalign;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage; consumes the EX/MEM register contents.
- Issues load/store requests to the data memory over a req/ready/rvalid handshake, aligns and extends load data, and generates byte enables for stores.
- Registers results into the MEM/WB register for the writeback stage.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
- WIDTH, 32, datapath width; byte-lane logic is defined for 32 only.
- ADDR_LEN, 32, PC/address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  EX/MEM holds a valid instruction.
- pc_i  in  ADDR_LEN  instruction PC.
- alu_out_i  in  WIDTH  ALU result; effective address for memory ops.
- rs2_data_i  in  WIDTH  store data.
- rd_addr_i  in  5  destination register.
- rf_w_en_i  in  1  register-file write enable.
- wbsel_i  in  2  writeback select: 00 ALU, 01 MEM, 10 PC+4.
- mem_w_en_i  in  1  store.
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- stall_o  out  1  upstream must hold all inputs stable while high.
- dmem_req  out  1  memory request.
- dmem_we  out  1  request is a store.
- dmem_addr  out  ADDR_LEN  word address, {alu_out_i[31:2],2'b00}.
- dmem_wdata  out  WIDTH  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  WIDTH  load data word.
- valid_o, pc_o, alu_out_o, rd_addr_o, rf_w_en_o, wbsel_o  out  -  MEM/WB register.
- load_data_o  out  WIDTH  aligned, extended load result.
- misalign_o  out  1  misaligned access flag, registered with MEM/WB.

Behaviour:
- Reset: all outputs 0, state IDLE, dmem_req 0. Reset mid-access aborts the access. dmem_rvalid/dmem_ready arriving after reset are ignored.
- Load = valid_i & wbsel_i==01 & rf_w_en_i. Store = valid_i & mem_w_en_i. Memop = load | store.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. No request is issued and there is no stall; MEM/WB loads on the next edge with rf_w_en_o=0 and misalign_o=1.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, non-memop or misaligned: stall_o=0; MEM/WB loads on the next edge (valid_o=valid_i).
- IDLE, aligned memop: stall_o=1; go to REQ; MEM/WB loads a bubble (valid_o=0).
- REQ: dmem_req=1, stall_o=1. dmem_addr/we/wdata/be are held stable until dmem_ready. On dmem_ready: store goes to DONE, load goes to WAIT. dmem_rvalid in REQ is ignored (protocol: rvalid comes at least 1 cycle after ready).
- WAIT: stall_o=1, dmem_req=0. On dmem_rvalid: capture aligned/extended data and go to DONE.
- DONE: stall_o=0. MEM/WB loads at the edge with valid_o=1 and load_data_o = captured value (0 for stores). Go to IDLE.
- Minimum memop latency: store 3 cycles (IDLE, REQ, DONE); load 4 cycles (IDLE, REQ, WAIT, DONE).
- Store byte enables: SB 0001<<off, SH 0011<<off, SW 1111. dmem_wdata: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
- Load alignment: select byte/halfword at off = addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
- Unused funct3 codes with a memop are treated as W.
- valid_i=0 in IDLE gives a bubble with all control fields registered as given, valid_o=0.

Test Plan:
- ALU op (wbsel 00, alu_out_i=0x1234, rd 5) in IDLE -> next cycle valid_o=1, alu_out_o=0x1234, rd_addr_o=5, stall_o never high, dmem_req never high.
- SB addr 0x103, rs2=0xAABBCCDD, dmem_ready tied 1 -> dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD; stall_o high 2 cycles; valid_o=1 on the 3rd edge.
- LB addr 0x102, rdata=0x00805566 with rvalid 3 cycles after ready -> load_data_o=0xFFFFFF80; LBU at the same address -> 0x00000080; stall_o held throughout the wait.
- LH addr 0x101 -> misalign_o=1, rf_w_en_o=0, dmem_req never asserted, no stall.
- dmem_ready held low 5 cycles in REQ -> dmem_req and dmem_addr stable all 5 cycles; completes after ready.
- Reset asserted in WAIT, then rvalid pulses -> state IDLE, all outputs 0, rvalid ignored, next ALU op completes normally.
